// File: rtl/vend_sequencer.sv
// vend_sequencer
//   Transaction controller for the vending machine datapath. Collects coin and
//   selection events into a running credit, checks selections against the
//   external price table, issues a one-cycle vend command and pays out change
//   (or a cancel refund) one coin at a time over a valid/ready handshake.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   coin_valid, coin_code        inserted coin pulse and denomination code
//   sel_valid, sel_idx           item button pulse and item index
//   cancel                       refund request pulse
//   price_idx, price_data        price table address (= sel_idx) and price
//   vend_valid, vend_idx         one-cycle vend command and item
//   coin_out_valid/ready/code    hopper handshake and coin to eject
//   credit, disp_value           current credit and display value (cents)
//   reject, reject_code          refused-event pulse and reason
//   busy                         high while vending or paying out
module vend_sequencer #(
    parameter int unsigned MAX_CREDIT = 500,
    parameter int unsigned CW         = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          coin_valid,
    input  logic [2:0]    coin_code,
    input  logic          sel_valid,
    input  logic [3:0]    sel_idx,
    input  logic          cancel,
    output logic [3:0]    price_idx,
    input  logic [CW-1:0] price_data,
    output logic          vend_valid,
    output logic [3:0]    vend_idx,
    output logic          coin_out_valid,
    input  logic          coin_out_ready,
    output logic [2:0]    coin_out_code,
    output logic [CW-1:0] credit,
    output logic [CW-1:0] disp_value,
    output logic          reject,
    output logic [1:0]    reject_code,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, HOLD, VEND, PAYOUT} stateT;

    localparam logic [CW:0] maxSum = (CW+1)'(MAX_CREDIT);

    function automatic logic [CW-1:0] coinValue(input logic [2:0] code);
        case (code)
            3'd0:    return CW'(5);
            3'd1:    return CW'(10);
            3'd2:    return CW'(25);
            3'd3:    return CW'(50);
            3'd4:    return CW'(100);
            3'd5:    return CW'(500);
            default: return '0;
        endcase
    endfunction

    function automatic logic [2:0] largestCoin(input logic [CW-1:0] amount);
        if (amount >= CW'(500))     return 3'd5;
        else if (amount >= CW'(100)) return 3'd4;
        else if (amount >= CW'(50))  return 3'd3;
        else if (amount >= CW'(25))  return 3'd2;
        else if (amount >= CW'(10))  return 3'd1;
        else                         return 3'd0;
    endfunction

    stateT         state, stateNext;
    logic [CW-1:0] creditReg, creditNext;
    logic [CW-1:0] dispReg, dispNext;
    logic [CW-1:0] changeReg, changeNext;
    logic [3:0]    vendIdxReg, vendIdxNext;
    logic          rejectReg, rejectNext;
    logic [1:0]    rejectCodeReg, rejectCodeNext;

    logic [CW:0]   coinSum;
    logic          coinOk;
    logic          selBad;
    logic [2:0]    payCode;
    logic [CW-1:0] changeLeft;

    // Sum kept one bit wider so an overflowing insertion cannot wrap past the ceiling.
    assign coinSum    = {1'b0, creditReg} + {1'b0, coinValue(coin_code)};
    assign coinOk     = (coin_code <= 3'd5) && (coinSum <= maxSum);
    assign selBad     = (sel_idx > 4'd8) || (price_data == '0);
    assign payCode    = largestCoin(changeReg);
    assign changeLeft = changeReg - coinValue(payCode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            creditReg     <= '0;
            dispReg       <= '0;
            changeReg     <= '0;
            vendIdxReg    <= '0;
            rejectReg     <= 1'b0;
            rejectCodeReg <= '0;
        end else begin
            state         <= stateNext;
            creditReg     <= creditNext;
            dispReg       <= dispNext;
            changeReg     <= changeNext;
            vendIdxReg    <= vendIdxNext;
            rejectReg     <= rejectNext;
            rejectCodeReg <= rejectCodeNext;
        end
    end

    always_comb begin
        stateNext      = state;
        creditNext     = creditReg;
        dispNext       = dispReg;
        changeNext     = changeReg;
        vendIdxNext    = vendIdxReg;
        rejectNext     = 1'b0;
        rejectCodeNext = '0;

        case (state)
            IDLE, HOLD: begin
                // Cancel wins the cycle even in IDLE, where it does nothing;
                // any select/coin arriving alongside it is dropped.
                if (cancel) begin
                    if (state == HOLD) begin
                        changeNext = creditReg;
                        creditNext = '0;
                        dispNext   = creditReg;
                        stateNext  = PAYOUT;
                    end
                end else if (sel_valid) begin
                    if (state == IDLE) begin
                        dispNext = price_data;
                        if (selBad) begin
                            rejectNext     = 1'b1;
                            rejectCodeNext = 2'd2;
                        end
                    end else if (selBad) begin
                        rejectNext     = 1'b1;
                        rejectCodeNext = 2'd2;
                    end else if (creditReg < price_data) begin
                        rejectNext     = 1'b1;
                        rejectCodeNext = 2'd1;
                        dispNext       = price_data;
                    end else begin
                        changeNext  = creditReg - price_data;
                        dispNext    = creditReg - price_data;
                        creditNext  = '0;
                        vendIdxNext = sel_idx;
                        stateNext   = VEND;
                    end
                end else if (coin_valid) begin
                    if (coinOk) begin
                        creditNext = coinSum[CW-1:0];
                        dispNext   = coinSum[CW-1:0];
                        stateNext  = HOLD;
                    end else begin
                        rejectNext     = 1'b1;
                        rejectCodeNext = 2'd0;
                    end
                end
            end
            VEND: begin
                stateNext = (changeReg != '0) ? PAYOUT : IDLE;
                if (coin_valid || sel_valid) begin
                    rejectNext     = 1'b1;
                    rejectCodeNext = 2'd3;
                end
            end
            PAYOUT: begin
                if (coin_out_ready) begin
                    changeNext = changeLeft;
                    dispNext   = changeLeft;
                    if (changeLeft == '0) stateNext = IDLE;
                end
                if (coin_valid || sel_valid) begin
                    rejectNext     = 1'b1;
                    rejectCodeNext = 2'd3;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign price_idx      = sel_idx;
    assign vend_valid     = (state == VEND);
    assign vend_idx       = vendIdxReg;
    assign coin_out_valid = (state == PAYOUT);
    assign coin_out_code  = (state == PAYOUT) ? payCode : 3'd0;
    assign credit         = creditReg;
    assign disp_value     = dispReg;
    assign reject         = rejectReg;
    assign reject_code    = rejectCodeReg;
    assign busy           = (state == VEND) || (state == PAYOUT);

endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer
//   Directed bench for vend_sequencer: purchases with multi-coin change,
//   credit ceiling, price/sold-out rejects, hopper back-pressure, busy
//   rejects, same-cycle event priority and asynchronous reset mid-payout.
module tb_vend_sequencer;

    localparam int unsigned CW = 9;

    logic          clk;
    logic          rst_n;
    logic          coin_valid;
    logic [2:0]    coin_code;
    logic          sel_valid;
    logic [3:0]    sel_idx;
    logic          cancel;
    logic [3:0]    price_idx;
    logic [CW-1:0] price_data;
    logic          vend_valid;
    logic [3:0]    vend_idx;
    logic          coin_out_valid;
    logic          coin_out_ready;
    logic [2:0]    coin_out_code;
    logic [CW-1:0] credit;
    logic [CW-1:0] disp_value;
    logic          reject;
    logic [1:0]    reject_code;
    logic          busy;

    int checks = 0;
    int errors = 0;

    vend_sequencer #(.MAX_CREDIT(500), .CW(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .coin_valid     (coin_valid),
        .coin_code      (coin_code),
        .sel_valid      (sel_valid),
        .sel_idx        (sel_idx),
        .cancel         (cancel),
        .price_idx      (price_idx),
        .price_data     (price_data),
        .vend_valid     (vend_valid),
        .vend_idx       (vend_idx),
        .coin_out_valid (coin_out_valid),
        .coin_out_ready (coin_out_ready),
        .coin_out_code  (coin_out_code),
        .credit         (credit),
        .disp_value     (disp_value),
        .reject         (reject),
        .reject_code    (reject_code),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Price table: item 3 and out-of-range items read as sold out (0).
    always_comb begin
        case (price_idx)
            4'd0:    price_data = 9'd100;
            4'd1:    price_data = 9'd175;
            4'd2:    price_data = 9'd125;
            4'd3:    price_data = 9'd0;
            4'd4:    price_data = 9'd150;
            4'd5:    price_data = 9'd50;
            4'd6:    price_data = 9'd75;
            4'd7:    price_data = 9'd200;
            4'd8:    price_data = 9'd250;
            default: price_data = 9'd0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic coin(input logic [2:0] code);
        coin_valid = 1'b1;
        coin_code  = code;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic select(input logic [3:0] idx);
        sel_valid = 1'b1;
        sel_idx   = idx;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic doCancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b1;
        coin_valid     = 1'b0;
        coin_code      = '0;
        sel_valid      = 1'b0;
        sel_idx        = '0;
        cancel         = 1'b0;
        coin_out_ready = 1'b0;

        // Reset
        #3 rst_n = 1'b0;
        tick();
        check("rst_credit", credit, 0);
        check("rst_disp", disp_value, 0);
        check("rst_vend_valid", vend_valid, 0);
        check("rst_coin_out_valid", coin_out_valid, 0);
        check("rst_coin_out_code", coin_out_code, 0);
        check("rst_reject", reject, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Price check in IDLE
        select(4'd4);
        check("idle_sel_disp", disp_value, 150);
        check("idle_sel_reject", reject, 0);
        check("idle_sel_busy", busy, 0);
        check("idle_sel_credit", credit, 0);

        // Invalid coin code
        coin(3'd6);
        check("bad_coin_reject", reject, 1);
        check("bad_coin_code", reject_code, 0);
        check("bad_coin_credit", credit, 0);

        // 100 + 100 + 25, buy item 2 (125), change 100
        coin(3'd4);
        check("t1_credit_100", credit, 100);
        check("t1_disp_100", disp_value, 100);
        coin(3'd4);
        check("t1_credit_200", credit, 200);
        coin(3'd2);
        check("t1_credit_225", credit, 225);
        select(4'd2);
        check("t1_vend_valid", vend_valid, 1);
        check("t1_vend_idx", vend_idx, 2);
        check("t1_vend_credit", credit, 0);
        check("t1_vend_disp", disp_value, 100);
        check("t1_vend_busy", busy, 1);
        check("t1_vend_no_coin", coin_out_valid, 0);
        tick();
        check("t1_vend_once", vend_valid, 0);
        check("t1_pay_valid", coin_out_valid, 1);
        check("t1_pay_code", coin_out_code, 4);
        coin_out_ready = 1'b1;
        tick();
        coin_out_ready = 1'b0;
        check("t1_done_valid", coin_out_valid, 0);
        check("t1_done_busy", busy, 0);
        check("t1_done_disp", disp_value, 0);

        // Credit ceiling, then refund of 500
        coin(3'd5);
        check("t2_credit_500", credit, 500);
        coin(3'd0);
        check("t2_over_reject", reject, 1);
        check("t2_over_code", reject_code, 0);
        check("t2_over_credit", credit, 500);
        tick();
        check("t2_reject_pulse", reject, 0);
        doCancel();
        check("t2_cancel_credit", credit, 0);
        check("t2_cancel_disp", disp_value, 500);
        check("t2_cancel_valid", coin_out_valid, 1);
        check("t2_cancel_code", coin_out_code, 5);
        coin_out_ready = 1'b1;
        tick();
        coin_out_ready = 1'b0;
        check("t2_done_valid", coin_out_valid, 0);
        check("t2_done_busy", busy, 0);

        // Insufficient credit, sold out, invalid item
        coin(3'd3);
        check("t3_credit_50", credit, 50);
        select(4'd1);
        check("t3_insuf_reject", reject, 1);
        check("t3_insuf_code", reject_code, 1);
        check("t3_insuf_disp", disp_value, 175);
        check("t3_insuf_credit", credit, 50);
        check("t3_insuf_busy", busy, 0);
        select(4'd3);
        check("t3_soldout_reject", reject, 1);
        check("t3_soldout_code", reject_code, 2);
        select(4'd9);
        check("t3_badidx_reject", reject, 1);
        check("t3_badidx_code", reject_code, 2);
        check("t3_badidx_credit", credit, 50);
        doCancel();
        check("t3_refund_code", coin_out_code, 3);
        coin_out_ready = 1'b1;
        tick();
        coin_out_ready = 1'b0;
        check("t3_done_valid", coin_out_valid, 0);

        // Credit 240, buy item 0 (100): change 140 = 100, 25, 10, 5
        coin(3'd4);
        coin(3'd4);
        coin(3'd2);
        coin(3'd1);
        coin(3'd0);
        check("t4_credit_240", credit, 240);
        select(4'd0);
        check("t4_vend_idx", vend_idx, 0);
        check("t4_vend_disp", disp_value, 140);
        tick();
        check("t4_c1_code", coin_out_code, 4);
        coin_out_ready = 1'b1;
        tick();
        coin_out_ready = 1'b0;
        check("t4_c2_code", coin_out_code, 2);
        check("t4_c2_disp", disp_value, 40);
        // Stall three cycles on the 25; a coin during payout is refused busy
        coin(3'd4);
        check("t4_busy_reject", reject, 1);
        check("t4_busy_code", reject_code, 3);
        check("t4_busy_credit", credit, 0);
        check("t4_stall1_valid", coin_out_valid, 1);
        check("t4_stall1_code", coin_out_code, 2);
        tick();
        check("t4_stall2_valid", coin_out_valid, 1);
        check("t4_stall2_code", coin_out_code, 2);
        tick();
        check("t4_stall3_valid", coin_out_valid, 1);
        check("t4_stall3_code", coin_out_code, 2);
        check("t4_stall3_disp", disp_value, 40);
        coin_out_ready = 1'b1;
        tick();
        check("t4_c3_code", coin_out_code, 1);
        check("t4_c3_disp", disp_value, 15);
        tick();
        check("t4_c4_code", coin_out_code, 0);
        check("t4_c4_valid", coin_out_valid, 1);
        tick();
        coin_out_ready = 1'b0;
        check("t4_done_valid", coin_out_valid, 0);
        check("t4_done_busy", busy, 0);
        check("t4_done_credit", credit, 0);

        // Same-cycle cancel + select + coin in HOLD: only the refund happens
        coin(3'd2);
        check("t5_credit_25", credit, 25);
        cancel     = 1'b1;
        sel_valid  = 1'b1;
        sel_idx    = 4'd0;
        coin_valid = 1'b1;
        coin_code  = 3'd4;
        tick();
        cancel     = 1'b0;
        sel_valid  = 1'b0;
        coin_valid = 1'b0;
        check("t5_prio_reject", reject, 0);
        check("t5_prio_credit", credit, 0);
        check("t5_prio_disp", disp_value, 25);
        check("t5_prio_valid", coin_out_valid, 1);
        check("t5_prio_code", coin_out_code, 2);
        check("t5_prio_no_vend", vend_valid, 0);
        coin_out_ready = 1'b1;
        tick();
        coin_out_ready = 1'b0;
        check("t5_done_valid", coin_out_valid, 0);

        // Reset in the middle of a payout
        coin(3'd4);
        coin(3'd4);
        select(4'd4);
        check("t6_vend_valid", vend_valid, 1);
        tick();
        check("t6_pay_valid", coin_out_valid, 1);
        check("t6_pay_code", coin_out_code, 3);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", coin_out_valid, 0);
        check("t6_rst_code", coin_out_code, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_disp", disp_value, 0);
        check("t6_rst_credit", credit, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_after_credit", credit, 0);
        check("t6_after_busy", busy, 0);
        check("t6_after_valid", coin_out_valid, 0);
        coin(3'd1);
        check("t6_after_coin", credit, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
- Synchronous transaction controller for the vending machine datapath.
- Accepts coin and selection events, and keeps the running credit.
- Checks each selection against the external price table (combinational lookup), then issues a one-cycle vend command.
- Pays out change or refunds coin-by-coin to the hopper over a valid/ready handshake. It replaces the edge-triggered event handling with one clocked FSM.

Parameters:
- MAX_CREDIT, 500, credit ceiling in cents; an insertion that would exceed it is rejected.
- CW, 9, credit/price width in bits; must hold MAX_CREDIT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- coin_valid  in  1  one-cycle pulse, coin/bill inserted
- coin_code  in  3  0=5c, 1=10c, 2=25c, 3=50c, 4=100c, 5=500c; 6–7 invalid
- sel_valid  in  1  one-cycle pulse, item button pressed
- sel_idx  in  4  item 0..8 (A1..C3); 9–15 invalid
- cancel  in  1  one-cycle pulse, cancel/refund request
- price_idx  out  4  price table address; equals sel_idx combinationally
- price_data  in  CW  price of price_idx, same cycle; 0 = sold out
- vend_valid  out  1  one-cycle vend pulse
- vend_idx  out  4  item being vended, valid with vend_valid
- coin_out_valid  out  1  hopper request, held until accepted
- coin_out_ready  in  1  hopper accepts when valid&&ready
- coin_out_code  out  3  coin to eject, same encoding as coin_code
- credit  out  CW  current credit (cents)
- disp_value  out  CW  value for the 7-segment formatter
- reject  out  1  one-cycle pulse, event refused
- reject_code  out  2  0=overflow/invalid coin, 1=insufficient, 2=sold out/invalid item, 3=busy
- busy  out  1  high in VEND and PAYOUT

Behaviour:
- Reset (async assert, sync release): state=IDLE.
  - All outputs 0: credit, disp_value, vend_valid, coin_out_valid, coin_out_code, reject, busy.
  - Internal change register = 0.
- States: IDLE (credit==0), HOLD (credit>0), VEND, PAYOUT.
- Same-cycle priority in IDLE/HOLD: cancel > sel_valid > coin_valid. Lower-priority events in that cycle are dropped silently, with no reject.
- Coin in IDLE/HOLD:
  - If value valid and credit+value <= MAX_CREDIT: credit updates next cycle; disp_value = new credit; go to HOLD.
  - Otherwise: reject, code 0; credit unchanged.
  - Sum is computed at CW+1 bits (no wrap).
- Select in IDLE (price check):
  - disp_value = price_data; no state change.
  - If price_data==0 or sel_idx>8: reject, code 2.
- Select in HOLD:
  - sel_idx>8 or price_data==0: reject, code 2; stay in HOLD.
  - credit < price: reject, code 1; disp_value = price; stay in HOLD.
  - Otherwise: change = credit − price; credit = 0; go to VEND.
- VEND: exactly one cycle.
  - vend_valid=1, vend_idx = latched sel_idx, disp_value = change.
  - Next state: PAYOUT if change>0, else IDLE.
- Cancel:
  - In HOLD: change = credit; credit = 0; disp_value = change; go to PAYOUT.
  - In IDLE: no effect.
- PAYOUT:
  - coin_out_code = largest coin <= change, from 500, 100, 50, 25, 10, 5.
  - coin_out_valid held high; code stable while waiting.
  - On a valid&&ready cycle: change −= coin value; next coin is presented the following cycle with no bubble required.
  - When change reaches 0: drop valid and go to IDLE.
  - Any change residue < 5 is not representable, since all credits are multiples of 5.
- Events while busy (VEND or PAYOUT):
  - coin_valid or sel_valid: reject, code 3; credit unchanged.
  - cancel: ignored.
- Reset mid-PAYOUT: remaining change is discarded; coin_out_valid drops asynchronously.
- Latency: event to credit/disp_value update = 1 cycle. Accepted select to vend_valid = 1 cycle. vend_valid to first coin_out_valid = 1 cycle.

Test Plan:
- Insert 100, 100, 25; select item 2 (price 125) → credit 225; one vend_valid with vend_idx=2. Payout: coin 4 (100), then 0 (5)... exact sequence is 100 → done, since 225−125=100 gives a single coin 4. Then IDLE.
- Credit 500, insert 5 → reject code 0, credit stays 500. Cancel → coin 5 (500) ejected, credit 0, IDLE.
- Credit 50, select price 175 → reject code 1, disp_value 175, state HOLD. Select price_data 0 → reject code 2.
- Credit 240, select price 100 → change 140 paid as 100, 25, 10, 5. Hold coin_out_ready low 3 cycles on the 25; valid and code must stay stable.
- During PAYOUT, pulse coin_valid → reject code 3, credit 0. Same cycle cancel+sel+coin in HOLD → only the refund is taken.
- Assert rst_n low mid-PAYOUT → all outputs 0 immediately; after release, IDLE with credit 0.
